bridge_n: RTL
=============

// Module: bridge_n
// PURPOSE
//  Parametrised CPU-to-peripheral bridge with NDEV device slots, wait-state handshake and built-in interrupt aggregator.
//  Sits between the CPU data-memory port (M stage) and the device ring (timers, UART, GPIO).
//  Decodes the address window, sequences each access, returns registered read data and errors.
//  Latches per-device interrupt edges into a maskable pending register driving one CPU interrupt line.
// PARAMETERS
//  NDEV           4         number of device slots (1..8)
//  SPAN_LOG2      4         log2 bytes per device slot (16 B)
//  DEV_BASE       32'h7F00  base byte address of slot 0; slots contiguous
//  IRQ_BASE       32'h7F80  base of internal regs: +0 PENDING, +4 MASK
//  TIMEOUT_CYC    16        max wait cycles per access (only with BRIDGE_TIMEOUT_EN)
// PORTS
//  clk        in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-low reset
//  PrAddr     in   32         CPU byte address, held until PrReady
//  PrWD       in   32         CPU write data, held until PrReady
//  PrWE       in   1          write request, held until PrReady
//  PrRE       in   1          read request, held until PrReady
//  PrRD       out  32         read data, valid while PrReady=1
//  PrReady    out  1          one-cycle completion strobe
//  PrErr      out  1          error flag, valid with PrReady
//  DEV_Addr   out  SPAN_LOG2  in-slot offset, registered at accept
//  DEV_WD     out  32         write data to devices, registered at accept
//  DEV_WE     out  NDEV       one-hot write pulse
//  DEV_RE     out  NDEV       one-hot read select, held through ACCESS
//  DEV_RD     in   NDEV*32    flattened read data, slot i at [32i+:32]
//  dev_ready  in   NDEV       device ack for the current access
//  dev_irq    in   NDEV       level interrupt requests (synchronous to clk)
//  irq_out    out  1          |(PENDING & MASK), registered
// BEHAVIOUR
//  Reset: state IDLE; PrRD=0, PrReady=0, PrErr=0, DEV_*=0, PENDING=0, MASK=0, irq_out=0.
//  FSM IDLE->ACCESS->DONE->IDLE; IDLE->DONE directly for internal reg or decode miss.
//  IDLE: request = PrWE|PrRE; PrWE&PrRE together is a write (read ignored, PrRD=0).
//   device hit: latch sel/offset/data, assert DEV_WE[sel] (write, 1 cycle) or DEV_RE[sel]; go ACCESS.
//   IRQ_BASE hit: perform reg access in this cycle, go DONE. Any other address: go DONE, PrErr=1, PrRD=0.
//  ACCESS: wait for dev_ready[sel]; on it capture DEV_RD[sel] (reads) and go DONE. dev_ready of other slots ignored.
//  DONE: PrReady=1 for exactly one cycle, PrRD/PrErr valid; return to IDLE. Min latency: 2 cycles dev, 1 cycle internal.
//  A new request is not accepted in the DONE cycle; CPU must drop or change the request after PrReady.
//  PENDING[i] set on 0->1 edge of dev_irq[i] (edge detect register resets to 0).
//  Write to +0 is write-1-to-clear; a set in the same cycle wins over the clear.
//  MASK (+4) RW, bits above NDEV read 0. irq_out updated one cycle after PENDING/MASK change.
//  Reset mid-access aborts immediately; device sees DEV_WE/DEV_RE drop asynchronously.
// CONFIGURATION
//  BRIDGE_TIMEOUT_EN defined: 5-bit-min counter runs in ACCESS.
//   Reaching TIMEOUT_CYC cycles without dev_ready -> DONE with PrErr=1, PrRD=0; counter clears in IDLE.
//  Undefined: ACCESS waits indefinitely; PrErr only for decode miss; no counter logic.
// STRUCTURE
//  Package bridge_pkg: state enum (IDLE, ACCESS, DONE), IRQ register offsets, slot-index width function (clog2 NDEV).
//  Sub-module bridge_irq_ctrl: edge detect, PENDING/MASK regs, irq_out; FSM, decode and read mux stay in bridge_n.
// TESTING
//  Write 0x1234 to 0x7F14, dev_ready[1] after 2 cyc -> DEV_WE=4'b0010 pulsed 1 cycle, DEV_Addr=4, PrReady 3 cycles after request.
//  Read 0x7F30, DEV_RD slot3=0xCAFEF00D, dev_ready immediate -> PrRD=0xCAFEF00D, PrErr=0, PrReady cycle 2.
//  Read 0x8000 -> PrReady next cycle, PrErr=1, PrRD=0, no DEV_WE/DEV_RE activity.
//  dev_irq[2] rises, MASK=4'b0100 -> PENDING=4'b0100, irq_out=1; W1C 0x4 to 0x7F80 -> irq_out=0; rise+clear same cycle -> bit stays 1.
//  BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=16, dev_ready never asserted -> PrReady with PrErr=1 after 16 ACCESS cycles.
//  reset low during ACCESS -> all outputs 0 at once, next request after reset completes normally.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the CPU-to-peripheral bridge: FSM states,
// interrupt register offsets and the slot-index width helper.
package bridge_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [31:0] IRQ_PENDING_OFS = 32'h0;
  localparam logic [31:0] IRQ_MASK_OFS    = 32'h4;

  // A single slot still needs a one-bit index.
  function automatic int sel_width(input int ndev);
    return (ndev > 1) ? $clog2(ndev) : 1;
  endfunction

endpackage

// File: rtl/bridge_irq_ctrl.sv
// Interrupt aggregator: rising-edge capture into PENDING (write-1-to-clear,
// set wins), a RW MASK register and a registered combined interrupt line.
module bridge_irq_ctrl #(
  parameter int NDEV = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NDEV-1:0] dev_irq,
  input  logic            pend_clr_en,
  input  logic            mask_wr_en,
  input  logic [NDEV-1:0] wr_data,
  output logic [NDEV-1:0] pending,
  output logic [NDEV-1:0] mask,
  output logic            irq_out
);

  logic [NDEV-1:0] irq_prev_reg;
  logic [NDEV-1:0] rise;
  logic [NDEV-1:0] clr;

  assign rise = dev_irq & ~irq_prev_reg;
  assign clr  = pend_clr_en ? wr_data : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev_reg <= '0;
      pending      <= '0;
      mask         <= '0;
      irq_out      <= 1'b0;
    end else begin
      irq_prev_reg <= dev_irq;
      // OR-ing the edge in after the clear lets a same-cycle edge survive.
      pending      <= (pending & ~clr) | rise;
      if (mask_wr_en)
        mask <= wr_data;
      irq_out      <= |(pending & mask);
    end
  end

endmodule

// File: rtl/bridge_n.sv
// CPU-to-peripheral bridge: address decode, per-access sequencing with device
// wait states, registered read data and errors. Optional macro BRIDGE_TIMEOUT_EN.
module bridge_n
  import bridge_pkg::*;
#(
  parameter int          NDEV        = 4,
  parameter int          SPAN_LOG2   = 4,
  parameter logic [31:0] DEV_BASE    = 32'h7F00,
  parameter logic [31:0] IRQ_BASE    = 32'h7F80,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          PrAddr,
  input  logic [31:0]          PrWD,
  input  logic                 PrWE,
  input  logic                 PrRE,
  output logic [31:0]          PrRD,
  output logic                 PrReady,
  output logic                 PrErr,
  output logic [SPAN_LOG2-1:0] DEV_Addr,
  output logic [31:0]          DEV_WD,
  output logic [NDEV-1:0]      DEV_WE,
  output logic [NDEV-1:0]      DEV_RE,
  input  logic [NDEV*32-1:0]   DEV_RD,
  input  logic [NDEV-1:0]      dev_ready,
  input  logic [NDEV-1:0]      dev_irq,
  output logic                 irq_out
);

  localparam int          SW        = sel_width(NDEV);
  localparam logic [31:0] DEV_SPAN  = 32'(NDEV) << SPAN_LOG2;
  localparam logic [31:0] PEND_ADDR = IRQ_BASE + IRQ_PENDING_OFS;
  localparam logic [31:0] MASK_ADDR = IRQ_BASE + IRQ_MASK_OFS;
  localparam logic [NDEV-1:0] SEL_ONE = NDEV'(1);

  state_t            state_reg, state_next;
  logic [SW-1:0]     sel_reg;
  logic              we_reg;
  logic [31:0]       rd_reg;
  logic              err_reg;

  logic [31:0]       dev_ofs;
  logic              dev_hit, pend_hit, mask_hit, req, accept;
  logic [SW-1:0]     req_sel;
  logic              pend_clr_en, mask_wr_en, dev_done, timeout;
  logic [NDEV-1:0]   pending, mask;
  logic [31:0]       dev_rd_arr [NDEV];

  for (genvar gi = 0; gi < NDEV; gi++) begin : g_rd
    assign dev_rd_arr[gi] = DEV_RD[32*gi +: 32];
  end

  // Unsigned wrap makes addresses below DEV_BASE fail the span compare too.
  assign dev_ofs  = PrAddr - DEV_BASE;
  assign dev_hit  = dev_ofs < DEV_SPAN;
  assign req_sel  = dev_ofs[SPAN_LOG2 +: SW];
  assign pend_hit = PrAddr[31:2] == PEND_ADDR[31:2];
  assign mask_hit = PrAddr[31:2] == MASK_ADDR[31:2];
  assign req      = PrWE | PrRE;
  assign accept   = (state_reg == IDLE) && req;

  assign pend_clr_en = accept && !dev_hit && pend_hit && PrWE;
  assign mask_wr_en  = accept && !dev_hit && !pend_hit && mask_hit && PrWE;
  assign dev_done    = dev_ready[sel_reg];

`ifdef BRIDGE_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 5) ? $clog2(TIMEOUT_CYC + 1) : 5;
  logic [TW-1:0] tmo_cnt_reg;

  assign timeout = (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      tmo_cnt_reg <= '0;
    else if (state_reg == ACCESS)
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    else
      tmo_cnt_reg <= '0;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req) state_next = dev_hit ? ACCESS : DONE;
      ACCESS:  if (dev_done || timeout) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      rd_reg    <= '0;
      err_reg   <= 1'b0;
      DEV_Addr  <= '0;
      DEV_WD    <= '0;
      DEV_WE    <= '0;
      DEV_RE    <= '0;
    end else begin
      state_reg <= state_next;
      DEV_WE    <= '0;
      case (state_reg)
        IDLE: begin
          if (req) begin
            rd_reg  <= '0;
            err_reg <= 1'b0;
            if (dev_hit) begin
              sel_reg  <= req_sel;
              we_reg   <= PrWE;
              DEV_Addr <= dev_ofs[SPAN_LOG2-1:0];
              DEV_WD   <= PrWD;
              if (PrWE)
                DEV_WE <= SEL_ONE << req_sel;
              else
                DEV_RE <= SEL_ONE << req_sel;
            end else if (pend_hit) begin
              if (!PrWE) rd_reg <= 32'(pending);
            end else if (mask_hit) begin
              if (!PrWE) rd_reg <= 32'(mask);
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (dev_done) begin
            DEV_RE <= '0;
            if (!we_reg) rd_reg <= dev_rd_arr[sel_reg];
          end else if (timeout) begin
            DEV_RE  <= '0;
            err_reg <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign PrReady = (state_reg == DONE);
  assign PrRD    = rd_reg;
  assign PrErr   = err_reg;

  bridge_irq_ctrl #(.NDEV(NDEV)) u_irq (
    .clk         (clk),
    .reset       (reset),
    .dev_irq     (dev_irq),
    .pend_clr_en (pend_clr_en),
    .mask_wr_en  (mask_wr_en),
    .wr_data     (PrWD[NDEV-1:0]),
    .pending     (pending),
    .mask        (mask),
    .irq_out     (irq_out)
  );

endmodule
